// File: rtl/smm_coo_tx.sv
// Sparse coordinate-stream transmitter: loads dense A/B matrices, then streams their
// nonzero (row, col, val) triples in row-major order on two independent channels.
module smm_coo_tx (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ld_start,
    input  logic       ld_size,
    input  logic       ld_valid,
    input  logic [3:0] ld_data,
    output logic       out_valid_size,
    output logic       out_size,
    output logic       out_valid_a,
    output logic [4:0] out_row_a,
    output logic [4:0] out_col_a,
    output logic [3:0] out_val_a,
    output logic       out_valid_b,
    output logic [4:0] out_row_b,
    output logic [4:0] out_col_b,
    output logic [3:0] out_val_b,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {IDLE, LOAD, SIZE, SEND} state_t;

    state_t     state_reg, state_next;
    logic       size_reg;
    logic [4:0] ld_row_reg, ld_col_reg;
    logic       ld_mat_reg;
    logic       out_valid_size_reg, out_size_reg, busy_reg, done_reg;

    logic start_ok, accept, last_col, last_row, last_elem, emit_phase, fin_all;

    function automatic logic [4:0] lowest_set(input logic [31:0] v);
        lowest_set = 5'd0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = i[4:0];
        end
    endfunction

    assign start_ok   = (state_reg == IDLE) && ld_start;
    assign accept     = (state_reg == LOAD) && ld_valid;
    assign last_col   = ld_col_reg == (size_reg ? 5'd31 : 5'd15);
    assign last_row   = ld_row_reg == (size_reg ? 5'd31 : 5'd15);
    assign last_elem  = ld_mat_reg && last_row && last_col;
    // Emission decisions start in SIZE so the first triple lands right after the size pulse.
    assign emit_phase = (state_reg == SIZE) || (state_reg == SEND);
    assign fin_all    = g_ch[0].fin_reg && g_ch[1].fin_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ld_start) state_next = LOAD;
            LOAD:    if (accept && last_elem) state_next = SIZE;
            SIZE:    state_next = SEND;
            SEND:    if (fin_all) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg          <= IDLE;
            size_reg           <= 1'b0;
            ld_row_reg         <= 5'd0;
            ld_col_reg         <= 5'd0;
            ld_mat_reg         <= 1'b0;
            out_valid_size_reg <= 1'b0;
            out_size_reg       <= 1'b0;
            busy_reg           <= 1'b0;
            done_reg           <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (start_ok) begin
                size_reg   <= ld_size;
                ld_row_reg <= 5'd0;
                ld_col_reg <= 5'd0;
                ld_mat_reg <= 1'b0;
            end else if (accept) begin
                if (last_col) begin
                    ld_col_reg <= 5'd0;
                    if (last_row) begin
                        ld_row_reg <= 5'd0;
                        ld_mat_reg <= 1'b1;
                    end else begin
                        ld_row_reg <= ld_row_reg + 5'd1;
                    end
                end else begin
                    ld_col_reg <= ld_col_reg + 5'd1;
                end
            end
            out_valid_size_reg <= accept && last_elem;
            out_size_reg       <= accept && last_elem && size_reg;
            busy_reg           <= state_next != IDLE;
            done_reg           <= (state_reg == SEND) && (state_next == IDLE);
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ch
            logic [3:0]  mem [1024];
            logic [31:0] bitmap_reg [32];
            logic [31:0] row_nz_reg;
            logic        fin_reg;
            logic        valid_reg;
            logic [4:0]  row_reg, col_reg;
            logic [3:0]  val_reg;

            logic        wr_en, any_row, emit;
            logic [4:0]  enc_row, enc_col;
            logic [31:0] cur_bits, cur_bits_next, row_nz_next;

            assign wr_en         = accept && (ld_mat_reg == (gi == 1));
            assign any_row       = |row_nz_reg;
            assign enc_row       = lowest_set(row_nz_reg);
            assign cur_bits      = bitmap_reg[enc_row];
            assign enc_col       = lowest_set(cur_bits);
            assign cur_bits_next = cur_bits & ~(32'd1 << enc_col);
            assign row_nz_next   = (cur_bits_next == 32'd0) ? (row_nz_reg & ~(32'd1 << enc_row))
                                                            : row_nz_reg;
            assign emit          = emit_phase && !fin_reg;

            always_ff @(posedge clk) begin
                if (wr_en) mem[{ld_row_reg, ld_col_reg}] <= ld_data;
            end

            // Registered read doubles as the value output register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) val_reg <= 4'd0;
                else        val_reg <= (emit && any_row) ? mem[{enc_row, enc_col}] : 4'd0;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int r = 0; r < 32; r++) bitmap_reg[r] <= 32'd0;
                    row_nz_reg <= 32'd0;
                    fin_reg    <= 1'b0;
                    valid_reg  <= 1'b0;
                    row_reg    <= 5'd0;
                    col_reg    <= 5'd0;
                end else begin
                    valid_reg <= emit;
                    row_reg   <= (emit && any_row) ? enc_row : 5'd0;
                    col_reg   <= (emit && any_row) ? enc_col : 5'd0;
                    if (start_ok) begin
                        for (int r = 0; r < 32; r++) bitmap_reg[r] <= 32'd0;
                        row_nz_reg <= 32'd0;
                        fin_reg    <= 1'b0;
                    end else if (wr_en) begin
                        if (ld_data != 4'd0) begin
                            bitmap_reg[ld_row_reg][ld_col_reg] <= 1'b1;
                            row_nz_reg[ld_row_reg]             <= 1'b1;
                        end
                    end else if (emit) begin
                        // An empty matrix still sends one (0,0,0) triple, then finishes.
                        fin_reg <= !any_row || (row_nz_next == 32'd0);
                        if (any_row) begin
                            bitmap_reg[enc_row] <= cur_bits_next;
                            row_nz_reg          <= row_nz_next;
                        end
                    end
                end
            end
        end
    endgenerate

    assign out_valid_size = out_valid_size_reg;
    assign out_size       = out_size_reg;
    assign busy           = busy_reg;
    assign done           = done_reg;
    assign out_valid_a    = g_ch[0].valid_reg;
    assign out_row_a      = g_ch[0].row_reg;
    assign out_col_a      = g_ch[0].col_reg;
    assign out_val_a      = g_ch[0].val_reg;
    assign out_valid_b    = g_ch[1].valid_reg;
    assign out_row_b      = g_ch[1].row_reg;
    assign out_col_b      = g_ch[1].col_reg;
    assign out_val_b      = g_ch[1].val_reg;

endmodule

// File: tb/tb_smm_coo_tx.sv
// Self-checking bench for smm_coo_tx: directed and random matrices are compressed by a
// reference model into expected triple lists and compared cycle by cycle with the streams.
module tb_smm_coo_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ld_start = 1'b0;
    logic       ld_size = 1'b0;
    logic       ld_valid = 1'b0;
    logic [3:0] ld_data = 4'd0;
    logic       out_valid_size, out_size;
    logic       out_valid_a, out_valid_b;
    logic [4:0] out_row_a, out_col_a, out_row_b, out_col_b;
    logic [3:0] out_val_a, out_val_b;
    logic       busy, done;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;

    logic [3:0]  ma [32][32];
    logic [3:0]  mb [32][32];
    logic [13:0] qa [$];
    logic [13:0] qb [$];
    logic [33:0] all_out;

    smm_coo_tx dut (
        .clk(clk), .rst_n(rst_n),
        .ld_start(ld_start), .ld_size(ld_size), .ld_valid(ld_valid), .ld_data(ld_data),
        .out_valid_size(out_valid_size), .out_size(out_size),
        .out_valid_a(out_valid_a), .out_row_a(out_row_a), .out_col_a(out_col_a), .out_val_a(out_val_a),
        .out_valid_b(out_valid_b), .out_row_b(out_row_b), .out_col_b(out_col_b), .out_val_b(out_val_b),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign all_out = {out_valid_size, out_size,
                      out_valid_a, out_row_a, out_col_a, out_val_a,
                      out_valid_b, out_row_b, out_col_b, out_val_b, busy, done};

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mats();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) begin
                ma[r][c] = 4'd0;
                mb[r][c] = 4'd0;
            end
    endtask

    function automatic logic [3:0] rnd_elem(input int dens);
        rnd_elem = ($urandom_range(99, 0) < dens) ? 4'($urandom_range(15, 1)) : 4'd0;
    endfunction

    task automatic rand_mats(input int n, input int dens_a, input int dens_b);
        clear_mats();
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                ma[r][c] = rnd_elem(dens_a);
                mb[r][c] = rnd_elem(dens_b);
            end
    endtask

    // Row-major list of nonzeros; an all-zero matrix yields a single (0,0,0).
    task automatic build_model(input int n);
        qa.delete();
        qb.delete();
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                if (ma[r][c] != 4'd0) qa.push_back({5'(r), 5'(c), ma[r][c]});
                if (mb[r][c] != 4'd0) qb.push_back({5'(r), 5'(c), mb[r][c]});
            end
        if (qa.size() == 0) qa.push_back(14'd0);
        if (qb.size() == 0) qb.push_back(14'd0);
    endtask

    task automatic load(input logic sz, input int gap_at, input int gap_len);
        int n, nn, cstart;
        n  = sz ? 32 : 16;
        nn = n * n;
        @(posedge clk); #1;
        ld_start = 1'b1;
        ld_size  = sz;
        cstart   = cyc;
        for (int e = 0; e < 2 * nn; e++) begin
            @(posedge clk); #1;
            if (e == 0) begin
                ld_start = 1'b0;
                chk("busy_after_start", 64'(busy), 64'd1);
            end
            if (e == gap_at) begin
                ld_valid = 1'b0;
                repeat (gap_len) begin @(posedge clk); #1; end
            end
            ld_valid = 1'b1;
            ld_data  = (e < nn) ? ma[e / n][e % n] : mb[(e - nn) / n][(e - nn) % n];
        end
        @(posedge clk); #1;
        ld_valid = 1'b0;
        ld_data  = 4'd0;
        chk("size_pulse", 64'({out_valid_size, out_size}), 64'({1'b1, sz}));
        chk("no_stream_in_size", 64'({out_valid_a, out_valid_b, done}), 64'd0);
        chk("load_latency", 64'(cyc - cstart), 64'(2 * nn + (gap_at >= 0 ? gap_len : 0) + 1));
    endtask

    task automatic stream(input bit poke, input int abort_at);
        int la, lb, lm;
        logic [14:0] ea, eb;
        la = qa.size();
        lb = qb.size();
        lm = (la > lb) ? la : lb;
        for (int k = 0; k <= lm; k++) begin
            @(posedge clk); #1;
            if (k == abort_at) return;
            ea = (k < la) ? {1'b1, qa[k]} : 15'd0;
            eb = (k < lb) ? {1'b1, qb[k]} : 15'd0;
            chk("stream_a", 64'({out_valid_a, out_row_a, out_col_a, out_val_a}), 64'(ea));
            chk("stream_b", 64'({out_valid_b, out_row_b, out_col_b, out_val_b}), 64'(eb));
            chk("done", 64'(done), 64'(k == lm));
            chk("busy", 64'(busy), 64'(k != lm));
            chk("size_quiet", 64'({out_valid_size, out_size}), 64'd0);
            if (poke) begin
                ld_start = (k == 1);
                ld_valid = (k == 1);
                ld_data  = (k == 1) ? 4'd5 : 4'd0;
            end
        end
        @(posedge clk); #1;
        chk("post_done_idle", 64'({busy, done, out_valid_a, out_valid_b}), 64'd0);
    endtask

    task automatic run(input logic sz, input int gap_at, input int gap_len, input bit poke,
                       input int abort_at);
        build_model(sz ? 32 : 16);
        $display("load size=%0d nnzA=%0d nnzB=%0d gap=%0d poke=%0d abort=%0d",
                 sz, qa.size(), qb.size(), gap_len, poke, abort_at);
        load(sz, gap_at, gap_len);
        stream(poke, abort_at);
    endtask

    initial begin
        #2;
        chk("reset_outputs", 64'(all_out), 64'd0);
        #12 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_reset", 64'(all_out), 64'd0);

        clear_mats();
        ma[0][0] = 4'd1; ma[3][5] = 4'd7; ma[15][15] = 4'd15; mb[2][9] = 4'd4;
        run(1'b0, -1, 0, 1'b0, -1);

        clear_mats();
        run(1'b1, -1, 0, 1'b0, -1);

        clear_mats();
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) ma[r][c] = 4'd1;
        mb[31][31] = 4'd9;
        run(1'b1, -1, 0, 1'b0, -1);

        clear_mats();
        for (int c = 0; c < 32; c++) begin
            ma[0][c]  = rnd_elem(30);
            ma[30][c] = rnd_elem(30);
            mb[c][31 - c] = rnd_elem(20);
        end
        ma[0][31] = 4'd3;
        ma[30][0] = 4'd2;
        run(1'b1, 700, 5, 1'b1, -1);

        rand_mats(16, 25, 10);
        run(1'b0, 100, 3, 1'b0, -1);
        rand_mats(32, 4, 6);
        run(1'b1, -1, 0, 1'b1, -1);
        rand_mats(16, 40, 0);
        run(1'b0, -1, 0, 1'b0, -1);

        rand_mats(32, 30, 30);
        run(1'b1, -1, 0, 1'b0, 10);
        #3 rst_n = 1'b0;
        #1 chk("reset_async_send", 64'(all_out), 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_after_abort", 64'(all_out), 64'd0);
        rand_mats(16, 15, 15);
        run(1'b0, -1, 0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
